// File: rtl/bram_reader_pkg.sv
// bram_reader_pkg: state encoding and sample width shared by the BRAM scan reader.
package bram_reader_pkg;
   localparam int DATA_W = 16;
   typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;
endpackage

// File: rtl/bram_scan_reader_peak_tracker.sv
// peak_tracker: running unsigned maximum of handshaken samples with the offset of its first occurrence.
module peak_tracker
   import bram_reader_pkg::*;
#(
   parameter int IDX_W = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              hs,
   input  logic [DATA_W-1:0] data,
   input  logic [IDX_W-1:0]  idx,
   output logic [DATA_W-1:0] peak_val,
   output logic [IDX_W-1:0]  peak_idx
);
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         peak_val <= '0;
         peak_idx <= '0;
      end else if (hs && data > peak_val) begin
         peak_val <= data;
         peak_idx <= idx;
      end
   end
endmodule

// File: rtl/bram_scan_reader.sv
// bram_scan_reader: sweeps a BRAM address window into a valid/ready stream, using the BRAM output register as the data register.
// Define BRAM_READER_PEAK_EN to build the per-window peak tracker; otherwise peak outputs read 0.
module bram_scan_reader
   import bram_reader_pkg::*;
#(
   parameter int ADDR_BITS = 11
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [ADDR_BITS-1:0] base_addr,
   input  logic [ADDR_BITS:0]   length,
   output logic                 busy,
   output logic                 done,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic                 mem_en,
   input  logic [DATA_W-1:0]    mem_data,
   output logic [DATA_W-1:0]    m_data,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic                 m_last,
   output logic [DATA_W-1:0]    peak_val,
   output logic [ADDR_BITS-1:0] peak_idx
);
   state_t               state, state_n;
   logic [ADDR_BITS-1:0] base;
   logic [ADDR_BITS:0]   len, issue_off;
   logic                 accept, issue, is_last, hs;

   assign accept   = state == IDLE && start && length != '0;
   // A new read may only be issued when the output register is free or being drained this cycle.
   assign issue    = state == READ && (!m_valid || m_ready);
   assign is_last  = issue_off == len - 1'b1;
   assign hs       = m_valid && m_ready;
   assign mem_en   = issue && !rst;
   assign mem_addr = base + issue_off[ADDR_BITS-1:0];
   assign m_data   = mem_data;
   assign busy     = state == READ || state == FLUSH;
   assign done     = state == DONE;

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start) state_n = length != '0 ? READ : DONE;
         READ:    if (issue && is_last) state_n = FLUSH;
         FLUSH:   if (hs) state_n = DONE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         base      <= '0;
         len       <= '0;
         issue_off <= '0;
         m_valid   <= 1'b0;
         m_last    <= 1'b0;
      end else begin
         state <= state_n;
         if (accept) begin
            base      <= base_addr;
            len       <= length;
            issue_off <= '0;
         end else if (issue) begin
            issue_off <= issue_off + 1'b1;
         end
         m_valid <= issue || (m_valid && !m_ready);
         if (issue) m_last <= is_last;
         else if (hs) m_last <= 1'b0;
      end
   end

`ifdef BRAM_READER_PEAK_EN
   logic [ADDR_BITS-1:0] hs_off;

   always_ff @(posedge clk) begin
      if (rst || accept) hs_off <= '0;
      else if (hs) hs_off <= hs_off + 1'b1;
   end

   peak_tracker #(.IDX_W(ADDR_BITS)) u_peak (
      .clk      (clk),
      .rst      (rst),
      .clr      (accept),
      .hs       (hs),
      .data     (m_data),
      .idx      (hs_off),
      .peak_val (peak_val),
      .peak_idx (peak_idx)
   );
`else
   assign peak_val = '0;
   assign peak_idx = '0;
`endif
endmodule

// File: tb/tb_bram_scan_reader.sv
// tb_bram_scan_reader: randomized window sweeps checked against an array-based model of the BRAM and stream rules.
module tb_bram_scan_reader;
   logic        clk = 1'b0;
   logic        rst, start, busy, done, mem_en, m_valid, m_ready, m_last;
   logic [10:0] base_addr, mem_addr, peak_idx;
   logic [11:0] length;
   logic [15:0] mem_data, m_data, peak_val;
   logic [15:0] mem [2048];
   int          vectors = 0;
   int          miscompares = 0;

   always #5 clk = ~clk;

   always @(posedge clk) if (mem_en) mem_data <= mem[mem_addr];

   bram_scan_reader #(.ADDR_BITS(11)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
      .busy(busy), .done(done), .mem_addr(mem_addr), .mem_en(mem_en), .mem_data(mem_data),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
      .peak_val(peak_val), .peak_idx(peak_idx)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_window(input logic [10:0] b, input logic [11:0] n, input int mode, input int spur);
      int          got, iss, pv, pi, ev;
      logic        stall, seen;
      logic [15:0] hold;
      logic        hold_last;
      got = 0; iss = 0; pv = 0; pi = 0; stall = 0; seen = 0; hold = '0; hold_last = 0;
      @(negedge clk);
      start = 1; base_addr = b; length = n; m_ready = 1;
      @(negedge clk);
      for (int k = 1; k <= n * 3 + 20 && !seen; k++) begin
         m_ready   = mode == 0 ? 1'b1 : mode == 1 ? k[0] : 1'($urandom_range(0, 1));
         start     = k == spur;
         base_addr = k == spur ? b + 11'h100 : b;
         length    = k == spur ? 12'd5 : n;
         #1;
         if (k == 1) chk("busy_t1", busy, n != 0);
         if (stall) begin
            chk("stall_valid", m_valid, 1);
            chk("stall_data", m_data, hold);
            chk("stall_last", m_last, hold_last);
         end
         if (mem_en) begin
            chk("addr", mem_addr, 11'(b + iss));
            iss++;
         end
         if (m_valid && !m_ready) chk("stall_en", mem_en, 0);
         stall = m_valid && !m_ready;
         hold = m_data;
         hold_last = m_last;
         if (m_valid && m_ready) begin
            chk("extra_beat", got < n, 1);
            ev = mem[11'(b + got)];
            chk("data", m_data, ev);
            chk("last", m_last, got == n - 1);
            if (ev > pv) begin pv = ev; pi = got; end
            got++;
         end
         if (done) begin
            seen = 1;
            chk("beats", got, n);
            chk("busy_done", busy, 0);
            if (mode == 0) chk("done_time", k, n == 0 ? 1 : n + 2);
            if (n != 0) begin
`ifdef BRAM_READER_PEAK_EN
               chk("peak_val", peak_val, pv);
               chk("peak_idx", peak_idx, pi);
`else
               chk("peak_val", peak_val, 0);
               chk("peak_idx", peak_idx, 0);
`endif
            end
         end
         @(negedge clk);
      end
      start = 0;
      chk("done_seen", seen, 1);
      #1;
      chk("done_pulse", done, 0);
      chk("busy_after", busy, 0);
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) mem[i] = 16'($urandom);
      rst = 1; start = 0; base_addr = '0; length = '0; m_ready = 1;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_valid", m_valid, 0);
      chk("rst_last", m_last, 0);
      chk("rst_en", mem_en, 0);
      chk("rst_peak", peak_val, 0);
      rst = 0;
      for (int i = 0; i < 4; i++) mem[16 + i] = 16'(i + 1);
      run_window(11'h010, 12'd4, 0, 0);
      run_window(11'h010, 12'd4, 1, 0);
      run_window(11'h7FE, 12'd4, 0, 0);
      run_window(11'h000, 12'd0, 0, 0);
      run_window(11'h100, 12'd8, 0, 3);
      @(negedge clk);
      start = 1; base_addr = 11'h020; length = 12'd8; m_ready = 1;
      @(negedge clk);
      start = 0;
      repeat (2) @(negedge clk);
      rst = 1;
      @(negedge clk);
      #1;
      chk("mid_rst_valid", m_valid, 0);
      chk("mid_rst_last", m_last, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_en", mem_en, 0);
      chk("mid_rst_peak_val", peak_val, 0);
      chk("mid_rst_peak_idx", peak_idx, 0);
      rst = 0;
      run_window(11'h020, 12'd8, 0, 0);
      mem[11'h040] = 16'd5; mem[11'h041] = 16'd9; mem[11'h042] = 16'd9; mem[11'h043] = 16'd3;
      run_window(11'h040, 12'd4, 0, 0);
      for (int i = 0; i < 6; i++) run_window(11'($urandom), 12'($urandom_range(1, 40)), 2, 0);
      run_window(11'h123, 12'd2048, 0, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
